regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (WE3/A3/WD3) between the pipeline
//  writeback stage and the long-latency unit (mul/div, load-miss return). Fixed
//  priority to writeback with a starvation guard for the long-latency side. Keeps
//  a scoreboard of registers awaiting long-latency results; flags busy read
//  operands so the hazard logic can stall. Sits between WB/LLU and register_file.
// PARAMETERS
//  DATA_W        32  write data width
//  ADDR_W        5   register address width (32 registers)
//  STARVE_LIMIT  4   cycles LLU may wait with lu_valid high before forced grant (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low
//  wb_valid     in   1       writeback write request
//  wb_ready     out  1       writeback request accepted this cycle
//  wb_addr      in   ADDR_W  writeback destination register
//  wb_data      in   DATA_W  writeback data
//  lu_valid     in   1       long-latency unit write request
//  lu_ready     out  1       LLU request accepted this cycle
//  lu_addr      in   ADDR_W  LLU destination register
//  lu_data      in   DATA_W  LLU data
//  pend_set     in   1       issue of a long-latency op; mark pend_addr pending
//  pend_addr    in   ADDR_W  destination of issued long-latency op
//  rd_a1/rd_a2  in   ADDR_W  read addresses being decoded (same as regfile A1/A2)
//  busy_a1/a2   out  1       operand register has a pending long-latency result
//  rf_we        out  1       to register_file WE3
//  rf_a3        out  ADDR_W  to register_file A3
//  rf_wd3       out  DATA_W  to register_file WD3
//  pending_vec  out  2^ADDR_W scoreboard state (debug/hazard visibility)
// BEHAVIOUR
//  Reset (reset=0, async): rf_we=0, rf_a3=0, rf_wd3=0, pending_vec=0, starve
//   counter=0, rf_src=0. wb_ready=lu_ready=0 while reset is asserted.
//  Handshake: transfer when valid&&ready. Requester holds valid/addr/data stable
//   until accepted. ready is combinational from arbitration state.
//  Arbitration: force_lu = lu_valid && (starve_cnt==STARVE_LIMIT).
//   wb_ready = !force_lu; lu_ready = force_lu || !wb_valid. Exactly one transfer max.
//  Starve counter: +1 each cycle lu_valid && !lu_ready, saturates at STARVE_LIMIT;
//   cleared on LLU transfer or any cycle lu_valid=0.
//  Output register stage (latency 1): on transfer, next edge rf_we <= (addr!=0),
//   rf_a3 <= addr, rf_wd3 <= data, rf_src <= (winner==LLU); else rf_we <= 0,
//   rf_a3/rf_wd3 hold. Writes to r0 are accepted and dropped (rf_we stays 0).
//  Scoreboard: edge with pend_set && pend_addr!=0 sets bit; edge with rf_we &&
//   rf_src clears bit rf_a3 (same edge the register file writes). Set and clear of
//   same register on same edge: set wins. pend_set to already-pending reg: no-op.
//   Bit 0 is constant 0.
//  busy_aN = pending_vec[rd_aN] && rd_aN!=0, combinational, no bypass.
//  Reset mid-operation: in-flight write in output stage is lost; scoreboard cleared;
//   requesters must re-present after reset release.
// STRUCTURE
//  mips_pkg: REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0, src enum {SRC_WB, SRC_LU}.
//  Sub-module regfile_scoreboard: pending_vec storage, set/clear priority, busy
//   lookup. Arbiter, starve counter and output stage stay in this module.
// TESTING
//  1 wb_valid only, addr=5 data=0xDEADBEEF -> wb_ready=1; next cycle rf_we=1,
//    rf_a3=5, rf_wd3=0xDEADBEEF; rf_we=0 the cycle after.
//  2 wb_valid and lu_valid held high continuously, STARVE_LIMIT=4 -> WB wins 4
//    cycles, 5th cycle lu_ready=1/wb_ready=0, counter clears, WB wins again.
//  3 pend_set addr=9; rd_a1=9 -> busy_a1=1 from next cycle; LLU write addr=9 ->
//    busy_a1=0 the cycle after rf_we (rf_src=LLU); WB write to 9 does not clear.
//  4 pend_set addr=9 on same edge LLU commit to 9 clears -> pending_vec[9]=1.
//  5 wb write addr=0 and pend_set addr=0 -> rf_we stays 0, pending_vec stays 0,
//    busy_a1=0 with rd_a1=0.
//  6 reset asserted mid-burst with pending bits set and rf_we=1 -> all outputs 0
//    immediately (async), readies 0; after release, fresh write completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths and write-source encoding
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      SRC_WB = 1'b0,
      SRC_LU = 1'b1
   } src_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending long-latency destination tracking and busy lookup
module regfile_scoreboard #(
   parameter int ADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 set_en,
   input  logic [ADDR_W-1:0]    set_addr,
   input  logic                 clr_en,
   input  logic [ADDR_W-1:0]    clr_addr,
   input  logic [ADDR_W-1:0]    rd_a1,
   input  logic [ADDR_W-1:0]    rd_a2,
   output logic                 busy_a1,
   output logic                 busy_a2,
   output logic [2**ADDR_W-1:0] pending_vec
);
   import mips_pkg::*;

   localparam int NREGS = 2**ADDR_W;

   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;
   logic [NREGS-1:0] pending_next;

   // Applying the set after the clear lets a fresh issue survive a same-edge commit.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_addr != '0)) begin
         set_mask[set_addr] = 1'b1;
      end
      if (clr_en) begin
         clr_mask[clr_addr] = 1'b1;
      end
      pending_next    = (pending_vec & ~clr_mask) | set_mask;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_vec <= '0;
      end else begin
         pending_vec <= pending_next;
      end
   end

   assign busy_a1 = pending_vec[rd_a1] && (rd_a1 != '0);
   assign busy_a2 = pending_vec[rd_a2] && (rd_a2 != '0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - write-port arbiter between writeback and long-latency unit
module regfile_wb_arbiter #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wb_valid,
   output logic                 wb_ready,
   input  logic [ADDR_W-1:0]    wb_addr,
   input  logic [DATA_W-1:0]    wb_data,
   input  logic                 lu_valid,
   output logic                 lu_ready,
   input  logic [ADDR_W-1:0]    lu_addr,
   input  logic [DATA_W-1:0]    lu_data,
   input  logic                 pend_set,
   input  logic [ADDR_W-1:0]    pend_addr,
   input  logic [ADDR_W-1:0]    rd_a1,
   input  logic [ADDR_W-1:0]    rd_a2,
   output logic                 busy_a1,
   output logic                 busy_a2,
   output logic                 rf_we,
   output logic [ADDR_W-1:0]    rf_a3,
   output logic [DATA_W-1:0]    rf_wd3,
   output logic [2**ADDR_W-1:0] pending_vec
);
   import mips_pkg::*;

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]  starve_cnt;
   logic              force_lu;
   logic              wb_xfer;
   logic              lu_xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   src_t              rf_src;

   // Readies are gated by reset so nothing is accepted while the block is held.
   assign force_lu = lu_valid && (starve_cnt == CNT_MAX);
   assign wb_ready = reset && !force_lu;
   assign lu_ready = reset && (force_lu || !wb_valid);
   assign wb_xfer  = wb_valid && wb_ready;
   assign lu_xfer  = lu_valid && lu_ready && !wb_xfer;

   always_comb begin
      sel_addr = wb_addr;
      sel_data = wb_data;
      if (lu_xfer) begin
         sel_addr = lu_addr;
         sel_data = lu_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!lu_valid || lu_xfer) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // r0 writes complete the handshake but never raise the write enable.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rf_we  <= 1'b0;
         rf_a3  <= '0;
         rf_wd3 <= '0;
         rf_src <= SRC_WB;
      end else if (wb_xfer || lu_xfer) begin
         rf_we  <= (sel_addr != '0);
         rf_a3  <= sel_addr;
         rf_wd3 <= sel_data;
         rf_src <= lu_xfer ? SRC_LU : SRC_WB;
      end else begin
         rf_we  <= 1'b0;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .set_en      (pend_set),
      .set_addr    (pend_addr),
      .clr_en      (rf_we && (rf_src == SRC_LU)),
      .clr_addr    (rf_a3),
      .rd_a1       (rd_a1),
      .rd_a2       (rd_a2),
      .busy_a1     (busy_a1),
      .busy_a2     (busy_a2),
      .pending_vec (pending_vec)
   );

endmodule
